mcu_arbiter: RTL and testbench

Shares the single MCU read port between the MMU table walk, instruction fetch and data fetch. Arbitrates one outstanding read at a time, drives the MCU read controls for a fixed access latency, captures the returned word and hands it back to the winning requester with a one-cycle valid pulse. Sits between the requesters and `mcu`, replacing their direct connections to the MCU port.

---
 rtl/mcu_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mcu_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_arbiter.sv
// ---------------------------------------------------------------------------
// mcu_arbiter
//
// Shares the single MCU read port between three requesters: the MMU table
// walk (bit 0), instruction fetch (bit 1) and data fetch (bit 2). Only one
// read is outstanding at a time. The winner's address and size are captured
// when it is granted and driven to the MCU together with out_mcu_ren for
// MCU_LATENCY cycles. The returned word is then registered and handed back
// with a one-cycle out_rsp_valid pulse.
//
// Handshake: in_req[i] is a level request. The requester holds it, together
// with its address and size, until it sees out_rsp_valid[i]. The address and
// size are sampled once, on the grant edge, and later changes are ignored.
// Dropping in_req during an access does not abort it. A request still high
// after the pulse counts as a new request in the following IDLE cycle.
//
// Ports:
//   in_clk         clock; all state changes on its rising edge
//   in_rst         asynchronous active-high reset
//   in_req         per-requester request (0 walk, 1 ifetch, 2 dfetch)
//   in_req_addr    requester i address in [i*ADDR_W +: ADDR_W]
//   in_req_size    requester i size in [2i +: 2]
//   out_gnt        one-hot grant, held from the grant to the end of the response
//   out_rsp_valid  one-hot, one-cycle response pulse
//   out_rsp_data   captured read data
//   out_mcu_ren    MCU read enable
//   out_mcu_addr   MCU address
//   out_mcu_size   MCU access size
//   in_mcu_data    MCU read data
// ---------------------------------------------------------------------------
module mcu_arbiter #(
    parameter int MCU_LATENCY = 2,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic [2:0]            in_req,
    input  logic [3*ADDR_W-1:0]   in_req_addr,
    input  logic [5:0]            in_req_size,
    output logic [2:0]            out_gnt,
    output logic [2:0]            out_rsp_valid,
    output logic [DATA_W-1:0]     out_rsp_data,
    output logic                  out_mcu_ren,
    output logic [ADDR_W-1:0]     out_mcu_addr,
    output logic [1:0]            out_mcu_size,
    input  logic [DATA_W-1:0]     in_mcu_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The counter is loaded with L-1, so BUSY lasts exactly L cycles.
    localparam logic [3:0] LAT_M1 = 4'(MCU_LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    // Which of requesters 1/2 was served last; holds 2'd1 or 2'd2.
    logic [1:0]          r_last_q, r_last_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [2:0]          valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ren_q, ren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;

    logic [1:0]          win_idx;
    logic [2:0]          win_oh;
    logic [ADDR_W-1:0]   sel_addr;
    logic [1:0]          sel_size;

    // Arbitration. The table walk has strict priority. Ifetch and dfetch
    // alternate: on a tie the one not served last wins.
    always_comb begin
        win_idx = 2'd2;
        if (in_req[0]) begin
            win_idx = 2'd0;
        end else if (in_req[1] && in_req[2]) begin
            win_idx = (r_last_q == 2'd1) ? 2'd2 : 2'd1;
        end else if (in_req[1]) begin
            win_idx = 2'd1;
        end else begin
            win_idx = 2'd2;
        end
        win_oh = 3'b001 << win_idx;
    end

    // Mux the winner's address and size for capture on the grant edge.
    always_comb begin
        sel_addr = in_req_addr[2*ADDR_W +: ADDR_W];
        sel_size = in_req_size[5:4];
        case (win_idx)
            2'd0: begin
                sel_addr = in_req_addr[0 +: ADDR_W];
                sel_size = in_req_size[1:0];
            end
            2'd1: begin
                sel_addr = in_req_addr[ADDR_W +: ADDR_W];
                sel_size = in_req_size[3:2];
            end
            default: begin
                sel_addr = in_req_addr[2*ADDR_W +: ADDR_W];
                sel_size = in_req_size[5:4];
            end
        endcase
    end

    // Next-state logic. Every output is registered, so each one changes
    // exactly on the FSM transition that owns it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_last_d = r_last_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ren_d    = ren_q;
        addr_d   = addr_q;
        size_d   = size_q;

        case (state_q)
            ST_IDLE: begin
                if (|in_req) begin
                    addr_d  = sel_addr;
                    size_d  = sel_size;
                    gnt_d   = win_oh;
                    ren_d   = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = ST_BUSY;
                    // The round-robin pointer only tracks requesters 1 and 2.
                    if (win_idx != 2'd0) begin
                        r_last_d = win_idx;
                    end
                end
            end

            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    // Last ren cycle: the MCU word is valid on this edge.
                    data_d  = in_mcu_data;
                    ren_d   = 1'b0;
                    valid_d = gnt_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                valid_d = 3'b000;
                gnt_d   = 3'b000;
                addr_d  = '0;
                size_d  = 2'b00;
                state_d = ST_IDLE;
            end

            default: begin
                valid_d = 3'b000;
                gnt_d   = 3'b000;
                ren_d   = 1'b0;
                addr_d  = '0;
                size_d  = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A reset in BUSY or RESP simply drops the access: valid_q is cleared
    // and the FSM restarts in IDLE, so no pulse follows.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            r_last_q <= 2'd2;
            gnt_q    <= 3'b000;
            valid_q  <= 3'b000;
            data_q   <= '0;
            ren_q    <= 1'b0;
            addr_q   <= '0;
            size_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_last_q <= r_last_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ren_q    <= ren_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
        end
    end

    assign out_gnt       = gnt_q;
    assign out_rsp_valid = valid_q;
    assign out_rsp_data  = data_q;
    assign out_mcu_ren   = ren_q;
    assign out_mcu_addr  = addr_q;
    assign out_mcu_size  = size_q;

endmodule

// File: tb/tb_mcu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mcu_arbiter
//
// Main instance at MCU_LATENCY=2, plus two instances at MCU_LATENCY=1 and 5
// for the latency sweep. The MCU model returns 0xA5 in the top byte and the
// address in the low bits, or a fixed word when fixed_en is set. Expected
// responses are pushed into exp_q when each request is issued. A monitor pops
// and compares the queue whenever out_rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_mcu_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int W  = 3 + DW;

    // ---------------- clock / reset ----------------
    logic in_clk = 1'b0;
    logic in_rst;
    always #5 in_clk = ~in_clk;

    // ---------------- main DUT signals ----------------
    logic [2:0]      in_req;
    logic [AW-1:0]   req_addr [3];
    logic [1:0]      req_size [3];
    logic [3*AW-1:0] in_req_addr;
    logic [5:0]      in_req_size;
    logic [2:0]      out_gnt;
    logic [2:0]      out_rsp_valid;
    logic [DW-1:0]   out_rsp_data;
    logic            out_mcu_ren;
    logic [AW-1:0]   out_mcu_addr;
    logic [1:0]      out_mcu_size;
    logic [DW-1:0]   in_mcu_data;

    logic            fixed_en;
    logic [DW-1:0]   fixed_val;

    assign in_req_addr = {req_addr[2], req_addr[1], req_addr[0]};
    assign in_req_size = {req_size[2], req_size[1], req_size[0]};

    function automatic logic [DW-1:0] echo(input logic [AW-1:0] a);
        return {8'hA5, 10'h000, a};
    endfunction

    assign in_mcu_data = !out_mcu_ren ? '0 : (fixed_en ? fixed_val : echo(out_mcu_addr));

    mcu_arbiter #(.MCU_LATENCY(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_req        (in_req),
        .in_req_addr   (in_req_addr),
        .in_req_size   (in_req_size),
        .out_gnt       (out_gnt),
        .out_rsp_valid (out_rsp_valid),
        .out_rsp_data  (out_rsp_data),
        .out_mcu_ren   (out_mcu_ren),
        .out_mcu_addr  (out_mcu_addr),
        .out_mcu_size  (out_mcu_size),
        .in_mcu_data   (in_mcu_data)
    );

    // ---------------- latency sweep instances ----------------
    logic [2:0]    sw_req   [2];
    logic [2:0]    sw_gnt   [2];
    logic [2:0]    sw_valid [2];
    logic [DW-1:0] sw_data  [2];
    logic          sw_ren   [2];
    logic [AW-1:0] sw_addr  [2];
    logic [1:0]    sw_size  [2];
    logic [DW-1:0] sw_mdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_sweep
        assign sw_mdata[g] = sw_ren[g] ? echo(sw_addr[g]) : '0;
        mcu_arbiter #(.MCU_LATENCY(g == 0 ? 1 : 5), .ADDR_W(AW), .DATA_W(DW)) u_sw (
            .in_clk        (in_clk),
            .in_rst        (in_rst),
            .in_req        (sw_req[g]),
            .in_req_addr   (in_req_addr),
            .in_req_size   (in_req_size),
            .out_gnt       (sw_gnt[g]),
            .out_rsp_valid (sw_valid[g]),
            .out_rsp_data  (sw_data[g]),
            .out_mcu_ren   (sw_ren[g]),
            .out_mcu_addr  (sw_addr[g]),
            .out_mcu_size  (sw_size[g]),
            .in_mcu_data   (sw_mdata[g])
        );
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge in_clk) begin
        if (!in_rst && out_rsp_valid != 3'b000) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_rsp: got valid=%b data=%h, no response expected",
                         out_rsp_valid, out_rsp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp", {out_rsp_valid, out_rsp_data}, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one transaction on the main instance, expecting requester 'win'
    // to be granted. Optionally change requester 2's address while BUSY.
    task automatic do_txn(input logic [2:0] req, input int win,
                          input bit chg, input logic [AW-1:0] chg_addr);
        logic [AW-1:0] ea;
        logic [1:0]    es;
        logic [DW-1:0] ed;
        logic [2:0]    oh;
        int            ren_cnt;
        int            lat;
        bit            done;
        ea = req_addr[win];
        es = req_size[win];
        ed = fixed_en ? fixed_val : echo(ea);
        oh = 3'b001 << win;
        exp_q.push_back({oh, ed});
        @(negedge in_clk);
        in_req  = req;
        ren_cnt = 0;
        lat     = 0;
        done    = 1'b0;
        for (int k = 1; k <= 30 && !done; k++) begin
            @(negedge in_clk);
            if (k == 1) begin
                check("gnt", W'(out_gnt), W'(oh));
                if (chg) req_addr[2] = chg_addr;
            end
            if (out_mcu_ren) begin
                ren_cnt++;
                check("mcu_addr", W'(out_mcu_addr), W'(ea));
                check("mcu_size", W'(out_mcu_size), W'(es));
            end
            if (out_rsp_valid != 3'b000) begin
                lat  = k;
                done = 1'b1;
            end
        end
        check("ren_cycles", W'(ren_cnt), W'(2));
        check("rsp_latency", W'(lat), W'(3));
    endtask

    task automatic sweep(input int k, input int lat);
        int  ren_cnt;
        int  got;
        bit  done;
        ren_cnt = 0;
        got     = 0;
        done    = 1'b0;
        @(negedge in_clk);
        sw_req[k] = 3'b010;
        for (int c = 1; c <= 30 && !done; c++) begin
            @(negedge in_clk);
            if (sw_ren[k]) ren_cnt++;
            if (sw_valid[k] != 3'b000) begin
                got  = c;
                done = 1'b1;
                check("sw_rsp", {sw_valid[k], sw_data[k]}, {3'b010, echo(req_addr[1])});
            end
        end
        sw_req[k] = 3'b000;
        check("sw_ren_cycles", W'(ren_cnt), W'(lat));
        check("sw_rsp_latency", W'(got), W'(lat + 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        in_rst      = 1'b1;
        in_req      = 3'b000;
        sw_req[0]   = 3'b000;
        sw_req[1]   = 3'b000;
        fixed_en    = 1'b0;
        fixed_val   = 32'hDEADBEEF;
        req_addr[0] = 14'h1000;
        req_addr[1] = 14'h0040;
        req_addr[2] = 14'h0100;
        req_size[0] = 2'b10;
        req_size[1] = 2'b01;
        req_size[2] = 2'b11;

        // Reset state
        #1;
        check("rst_gnt",   W'(out_gnt),       W'(0));
        check("rst_valid", W'(out_rsp_valid), W'(0));
        check("rst_data",  W'(out_rsp_data),  W'(0));
        check("rst_ren",   W'(out_mcu_ren),   W'(0));
        check("rst_addr",  W'(out_mcu_addr),  W'(0));
        check("rst_size",  W'(out_mcu_size),  W'(0));
        repeat (2) @(negedge in_clk);
        in_rst = 1'b0;

        // Priority: table walk always wins when present; 1/2 alternate.
        do_txn(3'b111, 0, 1'b0, '0);
        do_txn(3'b110, 1, 1'b0, '0);
        do_txn(3'b111, 0, 1'b0, '0);
        do_txn(3'b110, 2, 1'b0, '0);
        do_txn(3'b111, 0, 1'b0, '0);
        do_txn(3'b110, 1, 1'b0, '0);

        // Address sampled only on the grant edge.
        do_txn(3'b100, 2, 1'b1, 14'h0200);
        req_addr[2] = 14'h0100;

        // Round-robin fairness between ifetch and dfetch.
        for (int i = 0; i < 6; i++) begin
            do_txn(3'b110, (i % 2 == 0) ? 1 : 2, 1'b0, '0);
        end

        // Single ifetch with a fixed MCU word.
        fixed_en = 1'b1;
        do_txn(3'b010, 1, 1'b0, '0);
        in_req   = 3'b000;
        fixed_en = 1'b0;

        // Reset during the first BUSY cycle drops the access.
        @(negedge in_clk);
        in_req = 3'b010;
        @(negedge in_clk);
        check("rstb_gnt_before", W'(out_gnt), W'(3'b010));
        in_rst = 1'b1;
        #1;
        check("rstb_gnt",   W'(out_gnt),       W'(0));
        check("rstb_valid", W'(out_rsp_valid), W'(0));
        check("rstb_data",  W'(out_rsp_data),  W'(0));
        check("rstb_ren",   W'(out_mcu_ren),   W'(0));
        check("rstb_addr",  W'(out_mcu_addr),  W'(0));
        check("rstb_size",  W'(out_mcu_size),  W'(0));
        in_req = 3'b000;
        @(negedge in_clk);
        in_rst = 1'b0;
        repeat (8) @(negedge in_clk);
        check("rstb_no_gnt", W'(out_gnt), W'(0));
        // The round-robin pointer is back at 2, so ifetch wins the tie.
        do_txn(3'b110, 1, 1'b0, '0);
        in_req = 3'b000;

        // Latency sweep.
        sweep(0, 1);
        sweep(1, 5);

        repeat (6) @(negedge in_clk);
        check("queue_drained", W'(exp_q.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_vec++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
